sdram_arbiter: RTL and testbench

Two-client round-robin arbiter sitting directly upstream of the SDRAM controller. It presents two `sdram_ctrl_if.sub` ports to bus clients and drives one `sdram_ctrl_if.man` port into the controller. It serialises requests with one transaction outstanding, routes completions back to the issuing client, and converts a hung controller into an error completion via a watchdog.

---
 rtl/sdram_arb_pkg.sv | 7 +
 rtl/sdram_ctrl_if.sv | 27 ++
 rtl/sdram_arbiter.sv | 125 ++++++++++++
 tb/tb_sdram_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-client SDRAM request arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} arb_state_t;
    typedef enum logic {OP_RD, OP_WR} arb_op_t;

endpackage

// File: rtl/sdram_ctrl_if.sv
// Request/response bundle between bus clients, the arbiter and the SDRAM controller.
interface sdram_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned WORD_LEN = DATA_WIDTH / 8;

    logic [WORD_LEN-1:0]   wr;
    logic                  rd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  rdy;
    logic                  rvalid;
    logic                  wvalid;
    logic                  error;
    logic [DATA_WIDTH-1:0] read_data;

    modport sub (
        input  wr, rd, addr, write_data,
        output rdy, rvalid, wvalid, error, read_data
    );

    modport man (
        output wr, rd, addr, write_data,
        input  rdy, rvalid, wvalid, error, read_data
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-client round-robin arbiter in front of the SDRAM controller: one transaction
// in flight, completions routed to the issuing client, watchdog turns a hang into an error.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 1024
) (
    input logic       clk,
    input logic       rst_n,
    sdram_ctrl_if.sub c0,
    sdram_ctrl_if.sub c1,
    sdram_ctrl_if.man mem
);
    localparam int unsigned WORD_LEN = DATA_WIDTH / 8;
    localparam int unsigned CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t            state;
    arb_op_t               op;
    logic                  owner;
    logic                  last_grant;
    logic [CNT_W-1:0]      wait_cnt;
    logic [WORD_LEN-1:0]   issue_wr;
    logic                  issue_rd;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [DATA_WIDTH-1:0] issue_data;

    logic                  req0;
    logic                  req1;
    logic                  pick;
    logic                  pick_wr;
    logic [WORD_LEN-1:0]   pick_mask;
    logic [ADDR_WIDTH-1:0] pick_addr;
    logic [DATA_WIDTH-1:0] pick_data;
    logic                  done;
    logic                  timeout;
    logic                  rsp_rdy;
    logic                  rsp_rv;
    logic                  rsp_wv;
    logic                  rsp_err;
    logic [DATA_WIDTH-1:0] rsp_data;

    assign req0      = c0.rd | (|c0.wr);
    assign req1      = c1.rd | (|c1.wr);
    // On a tie the client that did not win last time goes first.
    assign pick      = (req0 && req1) ? ~last_grant : req1;
    assign pick_mask = pick ? c1.wr : c0.wr;
    assign pick_addr = pick ? c1.addr : c0.addr;
    assign pick_data = pick ? c1.write_data : c0.write_data;
    assign pick_wr   = |pick_mask;

    assign done    = (state == ST_WAIT) && ((op == OP_WR) ? mem.wvalid : mem.rvalid);
    assign timeout = (state == ST_WAIT) && !done && (wait_cnt == CNT_LAST);
    assign rsp_rdy = (state == ST_ISSUE) && mem.rdy;
    assign rsp_rv  = (op == OP_RD) && (done || timeout);
    assign rsp_wv  = (op == OP_WR) && (done || timeout);
    assign rsp_err = done ? mem.error : timeout;
    assign rsp_data = (timeout || !rst_n) ? '0 : mem.read_data;

    assign c0.rdy       = rsp_rdy && !owner;
    assign c0.rvalid    = rsp_rv && !owner;
    assign c0.wvalid    = rsp_wv && !owner;
    assign c0.error     = rsp_err && !owner;
    assign c0.read_data = rsp_data;
    assign c1.rdy       = rsp_rdy && owner;
    assign c1.rvalid    = rsp_rv && owner;
    assign c1.wvalid    = rsp_wv && owner;
    assign c1.error     = rsp_err && owner;
    assign c1.read_data = rsp_data;

    assign mem.wr         = issue_wr;
    assign mem.rd         = issue_rd;
    assign mem.addr       = issue_addr;
    assign mem.write_data = issue_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            op         <= OP_RD;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            wait_cnt   <= '0;
            issue_wr   <= '0;
            issue_rd   <= 1'b0;
            issue_addr <= '0;
            issue_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        owner      <= pick;
                        last_grant <= pick;
                        op         <= pick_wr ? OP_WR : OP_RD;
                        issue_wr   <= pick_mask;
                        issue_rd   <= !pick_wr;
                        issue_addr <= pick_addr;
                        issue_data <= pick_data;
                        wait_cnt   <= '0;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem.rdy) begin
                        issue_wr   <= '0;
                        issue_rd   <= 1'b0;
                        issue_data <= '0;
                        wait_cnt   <= '0;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (done || timeout) begin
                        state <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: transaction-level model checked every cycle plus
// literal expectations for each scenario.
module tb_sdram_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sdram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) c0_if ();
    sdram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) c1_if ();
    sdram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .c0    (c0_if),
        .c1    (c1_if),
        .mem   (mem_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: phase 0 = nothing granted, 1 = request presented, 2 = awaiting completion.
    int          m_phase, m_owner, m_last, m_waited, m_w;
    bit          m_is_wr, m_done, m_tmo, m_r0, m_r1;
    logic [3:0]  m_mask, e_own, e0, e1;
    logic [31:0] m_addr, m_wdata;

    // Event log gathered from DUT outputs.
    int   cyc, rdy_cyc, rv_cyc, n_c1_any, n_err_wv;
    int   n_rdy[2], n_rv[2], n_wv[2], n_err[2];
    logic [31:0] rv_data[2];
    int   rdy_order[$];
    bit   seen_mem, cap_rd, auto_drop;
    logic [3:0]  cap_wr;
    logic [31:0] cap_addr, cap_wdata;
    bit   drop_pend[2];

    always @(negedge clk) begin
        if (!rst_n) begin
            m_phase = 0; m_owner = 0; m_last = 1; m_waited = 0;
            m_is_wr = 0; m_mask = 0; m_addr = 0; m_wdata = 0;
            chk("rst_c0_rsp", {c0_if.rdy, c0_if.rvalid, c0_if.wvalid, c0_if.error}, 0);
            chk("rst_c1_rsp", {c1_if.rdy, c1_if.rvalid, c1_if.wvalid, c1_if.error}, 0);
            chk("rst_rdata", {c0_if.read_data, c1_if.read_data}, 0);
            chk("rst_mem", {mem_if.wr, mem_if.rd, mem_if.addr, mem_if.write_data}, 0);
        end else begin
            cyc++;
            m_done = (m_phase == 2) && (m_is_wr ? mem_if.wvalid : mem_if.rvalid);
            m_tmo  = (m_phase == 2) && !m_done && (m_waited == TO - 1);
            e_own  = {m_phase == 1 && mem_if.rdy, !m_is_wr && (m_done || m_tmo),
                      m_is_wr && (m_done || m_tmo), m_done ? mem_if.error : m_tmo};
            e0 = (m_owner == 0) ? e_own : 4'h0;
            e1 = (m_owner == 1) ? e_own : 4'h0;
            chk("c0_rsp", {c0_if.rdy, c0_if.rvalid, c0_if.wvalid, c0_if.error}, e0);
            chk("c1_rsp", {c1_if.rdy, c1_if.rvalid, c1_if.wvalid, c1_if.error}, e1);
            chk("c0_rdata", c0_if.read_data, m_tmo ? 32'h0 : mem_if.read_data);
            chk("c1_rdata", c1_if.read_data, m_tmo ? 32'h0 : mem_if.read_data);
            chk("mem_req", {mem_if.wr, mem_if.rd},
                {(m_phase == 1) ? m_mask : 4'h0, m_phase == 1 && !m_is_wr});
            chk("mem_addr", mem_if.addr, m_addr);
            chk("mem_wdata", mem_if.write_data, (m_phase == 1) ? m_wdata : 32'h0);

            if (c0_if.rdy) begin
                n_rdy[0]++; rdy_order.push_back(0); rdy_cyc = cyc;
                if (auto_drop) drop_pend[0] = 1;
            end
            if (c1_if.rdy) begin
                n_rdy[1]++; rdy_order.push_back(1); rdy_cyc = cyc;
                if (auto_drop) drop_pend[1] = 1;
            end
            if (c0_if.rvalid) begin n_rv[0]++; rv_data[0] = c0_if.read_data; rv_cyc = cyc; end
            if (c1_if.rvalid) begin n_rv[1]++; rv_data[1] = c1_if.read_data; rv_cyc = cyc; end
            if (c0_if.wvalid) n_wv[0]++;
            if (c1_if.wvalid) n_wv[1]++;
            if (c0_if.error) n_err[0]++;
            if (c1_if.error) n_err[1]++;
            if (c0_if.wvalid && c0_if.error) n_err_wv++;
            if (c1_if.rdy || c1_if.rvalid || c1_if.wvalid || c1_if.error) n_c1_any++;
            if (!seen_mem && (mem_if.rd || mem_if.wr != 0)) begin
                seen_mem = 1; cap_rd = mem_if.rd; cap_wr = mem_if.wr;
                cap_addr = mem_if.addr; cap_wdata = mem_if.write_data;
            end

            case (m_phase)
                0: begin
                    m_r0 = c0_if.rd || (c0_if.wr != 0);
                    m_r1 = c1_if.rd || (c1_if.wr != 0);
                    if (m_r0 || m_r1) begin
                        m_w = (m_r0 && m_r1) ? 1 - m_last : (m_r1 ? 1 : 0);
                        m_owner = m_w; m_last = m_w;
                        m_mask  = (m_w == 0) ? c0_if.wr : c1_if.wr;
                        m_addr  = (m_w == 0) ? c0_if.addr : c1_if.addr;
                        m_wdata = (m_w == 0) ? c0_if.write_data : c1_if.write_data;
                        m_is_wr = (m_mask != 0);
                        m_phase = 1;
                    end
                end
                1: if (mem_if.rdy) begin m_phase = 2; m_waited = 0; end
                default: if (m_done || m_tmo) m_phase = 0; else m_waited++;
            endcase
        end
    end

    // Scripted controller: accept after c_rdy_delay ISSUE cycles, complete at WAIT cycle c_done_delay.
    int          cph, ccnt, c_rdy_delay, c_done_delay;
    bit          c_done_en, c_err, c_was_rd;
    logic [31:0] c_rdata, c_bg_rdata;

    task automatic ctrl_reset();
        cph = 0; ccnt = 0;
        mem_if.rdy = 0; mem_if.rvalid = 0; mem_if.wvalid = 0; mem_if.error = 0;
        mem_if.read_data = c_bg_rdata;
    endtask

    task automatic ctrl_step();
        if (cph == 3) begin
            mem_if.rvalid = 0; mem_if.wvalid = 0; mem_if.error = 0;
            mem_if.read_data = c_bg_rdata; cph = 0;
        end
        if (cph == 0 && (mem_if.rd || mem_if.wr != 0)) begin cph = 1; ccnt = 0; end
        if (cph == 1) begin
            if (ccnt == c_rdy_delay) begin
                mem_if.rdy = 1; c_was_rd = mem_if.rd; cph = 2; ccnt = 0;
            end else ccnt++;
        end else if (cph == 2) begin
            mem_if.rdy = 0;
            if (c_done_en) begin
                if (ccnt == c_done_delay) begin
                    if (c_was_rd) mem_if.rvalid = 1; else mem_if.wvalid = 1;
                    mem_if.error = c_err; mem_if.read_data = c_rdata; cph = 3;
                end else ccnt++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
        if (drop_pend[0]) begin
            c0_if.wr = 0; c0_if.rd = 0; c0_if.addr = 0; c0_if.write_data = 0; drop_pend[0] = 0;
        end
        if (drop_pend[1]) begin
            c1_if.wr = 0; c1_if.rd = 0; c1_if.addr = 0; c1_if.write_data = 0; drop_pend[1] = 0;
        end
        ctrl_step();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic req(input int c, input bit rd, input logic [3:0] wr,
                       input logic [31:0] a, input logic [31:0] d);
        if (c == 0) begin
            c0_if.rd = rd; c0_if.wr = wr; c0_if.addr = a; c0_if.write_data = d;
        end else begin
            c1_if.rd = rd; c1_if.wr = wr; c1_if.addr = a; c1_if.write_data = d;
        end
    endtask

    task automatic clear_counts();
        n_c1_any = 0; n_err_wv = 0; seen_mem = 0; rdy_order.delete();
        for (int i = 0; i < 2; i++) begin
            n_rdy[i] = 0; n_rv[i] = 0; n_wv[i] = 0; n_err[i] = 0; rv_data[i] = 'x;
        end
    endtask

    task automatic ctrl_cfg(input int rdy_d, input int done_d, input bit en, input bit err,
                            input logic [31:0] rdata);
        c_rdy_delay = rdy_d; c_done_delay = done_d; c_done_en = en; c_err = err; c_rdata = rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int fair_exp[4] = '{0, 1, 0, 1};

    initial begin
        req(0, 0, 0, 0, 0); req(1, 0, 0, 0, 0);
        c_bg_rdata = 0; auto_drop = 1; drop_pend[0] = 0; drop_pend[1] = 0;
        ctrl_cfg(0, 1, 1, 0, 0); ctrl_reset(); clear_counts();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        chk("reset_mem_addr", mem_if.addr, 0);
        chk("reset_c0_rsp", {c0_if.rdy, c0_if.rvalid, c0_if.wvalid, c0_if.error}, 0);
        run(2);

        // Single write from c0.
        clear_counts(); ctrl_cfg(2, 5, 1, 0, 0);
        req(0, 0, 4'hF, 32'h100, 32'hDEADBEEF);
        run(16);
        chk("wr_mem_addr", cap_addr, 32'h100);
        chk("wr_mem_data", cap_wdata, 32'hDEADBEEF);
        chk("wr_mem_mask", {cap_wr, cap_rd}, {4'hF, 1'b0});
        chk("wr_c0_rdy_cnt", n_rdy[0], 1);
        chk("wr_c0_wvalid_cnt", n_wv[0], 1);
        chk("wr_c1_quiet", n_c1_any, 0);

        // Read routed to c1.
        clear_counts(); ctrl_cfg(1, 3, 1, 0, 32'h12345678);
        req(1, 1, 4'h0, 32'h200, 32'h0);
        run(14);
        chk("rd_mem_addr", {cap_addr, cap_rd}, {32'h200, 1'b1});
        chk("rd_c1_rvalid_cnt", n_rv[1], 1);
        chk("rd_c1_data", rv_data[1], 32'h12345678);
        chk("rd_c0_rvalid_cnt", n_rv[0], 0);

        // Fairness after a fresh reset: both clients request continuously.
        @(posedge clk); #1 rst_n = 0;
        run(2);
        @(posedge clk); #1 rst_n = 1;
        clear_counts(); ctrl_cfg(0, 1, 1, 0, 0); ctrl_reset(); auto_drop = 0;
        req(0, 0, 4'hF, 32'h10, 32'h11); req(1, 1, 4'h0, 32'h20, 32'h0);
        for (int i = 0; i < 60 && rdy_order.size() < 4; i++) tick();
        req(0, 0, 0, 0, 0); req(1, 0, 0, 0, 0); auto_drop = 1;
        chk("fair_count", rdy_order.size(), 4);
        for (int i = 0; i < 4 && i < rdy_order.size(); i++)
            chk($sformatf("fair_order%0d", i), rdy_order[i], fair_exp[i]);
        run(8);

        // Timeout on a c0 read; a late rvalid must be dropped.
        clear_counts(); ctrl_cfg(1, 0, 0, 0, 0);
        c_bg_rdata = 32'hAAAA5555; mem_if.read_data = c_bg_rdata;
        req(0, 1, 4'h0, 32'h300, 32'h0);
        for (int i = 0; i < 60 && n_rv[0] == 0; i++) tick();
        chk("tmo_rvalid_cnt", n_rv[0], 1);
        chk("tmo_error_cnt", n_err[0], 1);
        chk("tmo_rdata", rv_data[0], 32'h0);
        chk("tmo_latency", rv_cyc - rdy_cyc, TO);
        run(2);
        mem_if.rvalid = 1;
        tick();
        mem_if.rvalid = 0;
        run(2);
        chk("tmo_late_dropped", n_rv[0], 1);
        c_bg_rdata = 0; ctrl_reset();
        run(2);

        // Error passthrough on a write; rd and wr together count as a write.
        clear_counts(); ctrl_cfg(0, 2, 1, 1, 0);
        req(0, 1, 4'h3, 32'h40, 32'h55);
        run(12);
        chk("err_mem_req", {cap_wr, cap_rd}, {4'h3, 1'b0});
        chk("err_wvalid_cnt", n_wv[0], 1);
        chk("err_with_wvalid", n_err_wv, 1);
        c_err = 0;

        // Reset while waiting for completion.
        clear_counts(); ctrl_cfg(0, 0, 0, 0, 0);
        c_bg_rdata = 32'h77777777; mem_if.read_data = c_bg_rdata;
        req(0, 1, 4'h0, 32'h400, 32'h0);
        for (int i = 0; i < 20 && n_rdy[0] == 0; i++) tick();
        run(2);
        rst_n = 0;
        #1;
        chk("mid_rst_c0", {c0_if.rdy, c0_if.rvalid, c0_if.wvalid, c0_if.error}, 0);
        chk("mid_rst_c1", {c1_if.rdy, c1_if.rvalid, c1_if.wvalid, c1_if.error}, 0);
        chk("mid_rst_rdata", {c0_if.read_data, c1_if.read_data}, 0);
        chk("mid_rst_mem", {mem_if.wr, mem_if.rd, mem_if.addr, mem_if.write_data}, 0);
        c_bg_rdata = 0; ctrl_reset();
        run(2);
        rst_n = 1;
        clear_counts();
        tick();
        mem_if.rvalid = 1;
        tick();
        mem_if.rvalid = 0;
        ctrl_cfg(1, 2, 1, 0, 0);
        req(1, 0, 4'hF, 32'h500, 32'hCAFE);
        run(12);
        chk("post_rst_c0_rvalid", n_rv[0], 0);
        chk("post_rst_c1_rdy", n_rdy[1], 1);
        chk("post_rst_c1_wvalid", n_wv[1], 1);
        chk("post_rst_addr", cap_addr, 32'h500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
